zeroheti_obi_arbiter: RTL and testbench
=======================================

Name: zeroheti_obi_arbiter

Overview:
N-to-1 OBI arbiter that shares one OBI subordinate port (imem/dmem SRAM or the APB bridge) between several core-side managers: Ibex instr, Ibex data, and the debug SBA.
- Round-robin arbitration with a per-requester high-priority mask.
- Tracks outstanding transactions in an ID FIFO so responses are routed back in order.
- Sits between the crossbar manager ports and a single-port memory or peripheral.

Parameters:
NumReq, 3, number of requesting OBI managers (2..8)
AddrWidth, 32, OBI address width
DataWidth, 32, OBI data width; byte-enable width = DataWidth/8
MaxTrans, 2, max outstanding granted-but-unanswered transactions (1..4)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
prio_i  in  NumReq  high-priority mask; set bits win over clear bits
sbr_req_i  in  NumReq  per-requester request
sbr_gnt_o  out  NumReq  per-requester grant
sbr_addr_i  in  NumReq x AddrWidth  per-requester address
sbr_we_i  in  NumReq  per-requester write enable
sbr_be_i  in  NumReq x DataWidth/8  per-requester byte enables
sbr_wdata_i  in  NumReq x DataWidth  per-requester write data
sbr_rvalid_o  out  NumReq  per-requester response valid
sbr_rdata_o  out  DataWidth  response data, broadcast to all requesters
sbr_err_o  out  1  response error, broadcast to all requesters
mgr_req_o  out  1  shared-port request
mgr_gnt_i  in  1  shared-port grant
mgr_addr_o  out  AddrWidth  shared-port address
mgr_we_o  out  1  shared-port write enable
mgr_be_o  out  DataWidth/8  shared-port byte enables
mgr_wdata_o  out  DataWidth  shared-port write data
mgr_rvalid_i  in  1  shared-port response valid
mgr_rdata_i  in  DataWidth  shared-port response data
mgr_err_i  in  1  shared-port response error
protocol_err_o  out  1  sticky flag: response arrived with no outstanding transaction

Behaviour:
- Reset state:
  - RR pointer = 0, hold register invalid, ID FIFO empty, protocol_err_o = 0.
  - All outputs 0: sbr_gnt_o, sbr_rvalid_o, mgr_req_o, mgr_addr_o, mgr_we_o, mgr_be_o, mgr_wdata_o, sbr_rdata_o, sbr_err_o.
- Selection:
  - Candidates = sbr_req_i & prio_i if that value is nonzero, else sbr_req_i.
  - Winner = first candidate at index >= RR pointer, wrapping modulo NumReq.
- FSM states, IDLE and HOLD:
  - IDLE → HOLD: mgr_req_o=1 and mgr_gnt_i=0. The winner index is latched and stays selected until granted (OBI requires a stable address), even if a higher-priority request appears.
  - HOLD → IDLE: on mgr_gnt_i.
- Request path (combinational, zero latency):
  - mgr_req_o = any candidate AND FIFO not full.
  - mgr_addr_o, mgr_we_o, mgr_be_o, mgr_wdata_o are muxed from the selected requester.
  - sbr_gnt_o[sel] = mgr_gnt_i & mgr_req_o. All other grant bits are 0.
- On a handshake (mgr_req_o & mgr_gnt_i):
  - push sel into the ID FIFO;
  - RR pointer = (sel+1) mod NumReq.
- Response path (combinational, zero latency):
  - on mgr_rvalid_i: sbr_rvalid_o[FIFO head] = 1, then pop;
  - sbr_rdata_o = mgr_rdata_i, sbr_err_o = mgr_err_i.
- FIFO full (count == MaxTrans):
  - mgr_req_o = 0, even if an rvalid pops in the same cycle (no bypass). Issue resumes the next cycle.
- Simultaneous push and pop when not full: count is unchanged and FIFO order is preserved.
- mgr_rvalid_i with FIFO empty: all sbr_rvalid_o bits stay 0 and protocol_err_o is set; it clears only on reset.
- A requester that drops sbr_req_i while in HOLD is a protocol violation. The arbiter keeps driving the latched index's current signals.
- Reset mid-operation: FIFO and HOLD state are discarded and in-flight responses are lost. The downstream block is reset by the same rst_i.

Optional Feature:
Macro ZEROHETI_ARB_STATS_EN.
- Defined:
  - adds output port grant_cnt_o, NumReq x 16, one saturating counter per requester, incremented on each handshake for that requester;
  - adds output port stall_cnt_o, 16, a saturating counter of cycles with mgr_req_o=1 and mgr_gnt_i=0;
  - all counters reset to 0 and saturate at 16'hFFFF.
- Not defined: neither port exists and no counter logic is synthesised.

Test Plan:
- RR fairness: NumReq=3, all sbr_req_i=3'b111, prio_i=0, mgr_gnt_i=1, responses 1 cycle later → grants go to 0, 1, 2, 0, 1, 2; each sbr_rvalid_o matches the granted ID.
- Priority: sbr_req_i=3'b111, prio_i=3'b001 → requester 0 granted every cycle; clear prio_i → requesters 1 and 2 served next.
- Hold: req 2 alone, mgr_gnt_i low for 3 cycles, then req 0 with prio_i=3'b001 raised → mgr_addr_o stays at req 2's address until the grant; req 0 is granted afterwards.
- Backpressure: MaxTrans=2, two grants with no rvalid → mgr_req_o=0 on the third cycle; one rvalid that cycle → mgr_req_o=1 the following cycle; two rvalids return to IDs in grant order.
- Protocol error: mgr_rvalid_i=1 with FIFO empty → protocol_err_o=1 and stays 1; sbr_rvalid_o=0; rst_i clears it.
- Stats (ZEROHETI_ARB_STATS_EN): 5 grants to req 1 and 3 stall cycles → grant_cnt_o[1]=5, stall_cnt_o=3; forced 70000 grants → grant_cnt_o saturates at 16'hFFFF.

Source files
------------

// File: rtl/zeroheti_obi_arbiter.sv
// zeroheti_obi_arbiter: N-to-1 OBI arbiter sharing one subordinate port between managers.
//
// Round-robin selection among requesters, with a high-priority mask: when any priority
// requester is active, only priority requesters compete. A request that is not granted
// is held (index latched) until granted so the address stays stable. Granted requester
// IDs go into an in-order FIFO so responses are routed back to the right requester.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   prio_i                  per-requester high-priority mask
//   sbr_*                   per-requester OBI request/grant/response (rdata/err broadcast)
//   mgr_*                   shared OBI port towards the memory or peripheral
//   protocol_err_o          sticky: response arrived with no outstanding transaction
//   grant_cnt_o, stall_cnt_o  saturating statistics, only with ZEROHETI_ARB_STATS_EN defined
module zeroheti_obi_arbiter #(
  parameter int unsigned NumReq    = 3,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxTrans  = 2
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NumReq-1:0]                       prio_i,
  input  logic [NumReq-1:0]                       sbr_req_i,
  output logic [NumReq-1:0]                       sbr_gnt_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]        sbr_addr_i,
  input  logic [NumReq-1:0]                       sbr_we_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]      sbr_be_i,
  input  logic [NumReq-1:0][DataWidth-1:0]        sbr_wdata_i,
  output logic [NumReq-1:0]                       sbr_rvalid_o,
  output logic [DataWidth-1:0]                    sbr_rdata_o,
  output logic                                    sbr_err_o,
  output logic                                    mgr_req_o,
  input  logic                                    mgr_gnt_i,
  output logic [AddrWidth-1:0]                    mgr_addr_o,
  output logic                                    mgr_we_o,
  output logic [DataWidth/8-1:0]                  mgr_be_o,
  output logic [DataWidth-1:0]                    mgr_wdata_o,
  input  logic                                    mgr_rvalid_i,
  input  logic [DataWidth-1:0]                    mgr_rdata_i,
  input  logic                                    mgr_err_i,
`ifdef ZEROHETI_ARB_STATS_EN
  output logic [NumReq-1:0][15:0]                 grant_cnt_o,
  output logic [15:0]                             stall_cnt_o,
`endif
  output logic                                    protocol_err_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  typedef enum logic {StIdle, StHold} state_e;

  state_e                         state_q, state_d;
  logic [IdxW-1:0]                rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]                hold_idx_q, hold_idx_d;
  logic [MaxTrans-1:0][IdxW-1:0]  fifo_q, fifo_d;
  logic [PtrW-1:0]                wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]                cnt_q, cnt_d;
  logic                           perr_q, perr_d;

  logic [NumReq-1:0] cand_prio, cand;
  logic [IdxW-1:0]   win_idx, scan_idx, sel;
  logic              win_found;
  logic              fifo_full, fifo_empty, handshake, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxTrans - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Priority requesters mask out the rest only when at least one of them is requesting.
  assign cand_prio = sbr_req_i & prio_i;
  assign cand      = (|cand_prio) ? cand_prio : sbr_req_i;

  // First candidate at or after the round-robin pointer, wrapping.
  always_comb begin
    win_idx   = rr_ptr_q;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      scan_idx = IdxW'((32'(rr_ptr_q) + i) % NumReq);
      if (!win_found && cand[scan_idx]) begin
        win_idx   = scan_idx;
        win_found = 1'b1;
      end
    end
  end

  assign sel        = (state_q == StHold) ? hold_idx_q : win_idx;
  assign fifo_full  = (cnt_q == CntW'(MaxTrans));
  assign fifo_empty = (cnt_q == '0);

  // No bypass: a pop in the same cycle does not free a slot for issue.
  assign mgr_req_o   = ((state_q == StHold) || win_found) && !fifo_full;
  assign handshake   = mgr_req_o & mgr_gnt_i;
  assign mgr_addr_o  = mgr_req_o ? sbr_addr_i[sel]  : '0;
  assign mgr_we_o    = mgr_req_o ? sbr_we_i[sel]    : 1'b0;
  assign mgr_be_o    = mgr_req_o ? sbr_be_i[sel]    : '0;
  assign mgr_wdata_o = mgr_req_o ? sbr_wdata_i[sel] : '0;

  always_comb begin
    sbr_gnt_o      = '0;
    sbr_gnt_o[sel] = handshake;
  end

  assign pop = mgr_rvalid_i & ~fifo_empty;

  always_comb begin
    sbr_rvalid_o                 = '0;
    sbr_rvalid_o[fifo_q[rptr_q]] = pop;
  end

  assign sbr_rdata_o    = mgr_rdata_i;
  assign sbr_err_o      = mgr_err_i;
  assign protocol_err_o = perr_q;

  always_comb begin
    state_d    = state_q;
    hold_idx_d = hold_idx_q;
    rr_ptr_d   = rr_ptr_q;
    fifo_d     = fifo_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    perr_d     = perr_q | (mgr_rvalid_i & fifo_empty);

    unique case (state_q)
      StIdle: begin
        if (mgr_req_o && !mgr_gnt_i) begin
          state_d    = StHold;
          hold_idx_d = win_idx;
        end
      end
      StHold: begin
        if (handshake) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (handshake) begin
      fifo_d[wptr_q] = sel;
      wptr_d         = ptr_inc(wptr_q);
      rr_ptr_d       = IdxW'((32'(sel) + 1) % NumReq);
    end
    if (pop) rptr_d = ptr_inc(rptr_q);

    unique case ({handshake, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      hold_idx_q <= '0;
      rr_ptr_q   <= '0;
      fifo_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_idx_q <= hold_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      fifo_q     <= fifo_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      perr_q     <= perr_d;
    end
  end

`ifdef ZEROHETI_ARB_STATS_EN
  logic [NumReq-1:0][15:0] grant_cnt_q, grant_cnt_d;
  logic [15:0]             stall_cnt_q, stall_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (handshake && (grant_cnt_q[sel] != 16'hFFFF)) begin
      grant_cnt_d[sel] = grant_cnt_q[sel] + 16'd1;
    end
    if (mgr_req_o && !mgr_gnt_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign grant_cnt_o = grant_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_zeroheti_obi_arbiter.sv
module tb_zeroheti_obi_arbiter;

  localparam int N    = 3;
  localparam int MAXT = 2;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic [2:0]       prio, req, gnt_o, rvalid_o;
  logic [2:0][31:0] addr, wdata;
  logic [2:0]       we;
  logic [2:0][3:0]  be;
  logic [31:0]      rdata_o, mgr_addr, mgr_wdata, mgr_rdata;
  logic             err_o, mgr_req, mgr_gnt, mgr_we, mgr_rvalid, mgr_err, perr;
  logic [3:0]       mgr_be;
`ifdef ZEROHETI_ARB_STATS_EN
  logic [2:0][15:0] grant_cnt;
  logic [15:0]      stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  zeroheti_obi_arbiter #(
    .NumReq(N), .AddrWidth(32), .DataWidth(32), .MaxTrans(MAXT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .prio_i(prio),
    .sbr_req_i(req), .sbr_gnt_o(gnt_o), .sbr_addr_i(addr), .sbr_we_i(we),
    .sbr_be_i(be), .sbr_wdata_i(wdata), .sbr_rvalid_o(rvalid_o),
    .sbr_rdata_o(rdata_o), .sbr_err_o(err_o),
    .mgr_req_o(mgr_req), .mgr_gnt_i(mgr_gnt), .mgr_addr_o(mgr_addr), .mgr_we_o(mgr_we),
    .mgr_be_o(mgr_be), .mgr_wdata_o(mgr_wdata), .mgr_rvalid_i(mgr_rvalid),
    .mgr_rdata_i(mgr_rdata), .mgr_err_i(mgr_err),
`ifdef ZEROHETI_ARB_STATS_EN
    .grant_cnt_o(grant_cnt), .stall_cnt_o(stall_cnt),
`endif
    .protocol_err_o(perr)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    req = '0; prio = '0; mgr_gnt = 1'b0; mgr_rvalid = 1'b0; mgr_err = 1'b0;
    mgr_rdata = '0; we = '0;
    for (int i = 0; i < N; i++) begin
      addr[i] = 32'h1000_0000 + 32'(i) * 32'h100; wdata[i] = 32'hD000_0000 + 32'(i);
      be[i] = 4'hF;
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk_i);
    rst_i = 1'b1;
    clear_inputs();
    addr = '0; wdata = '0; be = '0;
    #1;
    check({tag, " perr"}, perr, 0);
    check({tag, " gnt"}, gnt_o, 0);
    check({tag, " rvalid"}, rvalid_o, 0);
    check({tag, " mgr_req"}, mgr_req, 0);
    check({tag, " mgr_addr"}, mgr_addr, 0);
    check({tag, " mgr_we/be/wdata"}, {mgr_we, mgr_be, mgr_wdata}, 0);
    check({tag, " rdata/err"}, {err_o, rdata_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    clear_inputs();
  endtask

  typedef struct {
    logic [2:0] req, prio;
    logic       gnt, rv;
    logic [2:0] e_gnt, e_rv;
    logic       e_req, e_perr;
  } vec_t;
  vec_t vecs[22];

  // Reference model state: queue of outstanding IDs plus pointer/hold bookkeeping.
  int m_q[$];
  int m_rr, m_hidx;
  bit m_hold, m_perr;

  task automatic model_cycle(input int cyc);
    int cands, s, idx;
    bit found, e_req, full;
    logic [2:0] e_gnt, e_rv;
    full = (m_q.size() == MAXT);
    s = 0; found = 0;
    if (m_hold) begin
      s = m_hidx; found = 1;
    end else begin
      cands = int'(req & prio);
      if (cands == 0) cands = int'(req);
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (!found && cands[idx]) begin s = idx; found = 1; end
      end
    end
    e_req = found && !full;
    e_gnt = (e_req && mgr_gnt) ? 3'(1 << s) : 3'b000;
    e_rv  = (mgr_rvalid && m_q.size() > 0) ? 3'(1 << m_q[0]) : 3'b000;
    check($sformatf("rnd%0d mgr_req", cyc), mgr_req, e_req);
    check($sformatf("rnd%0d gnt", cyc), gnt_o, e_gnt);
    check($sformatf("rnd%0d addr", cyc), mgr_addr, e_req ? addr[s] : 0);
    check($sformatf("rnd%0d we/be", cyc), {mgr_we, mgr_be}, e_req ? {we[s], be[s]} : 0);
    check($sformatf("rnd%0d wdata", cyc), mgr_wdata, e_req ? wdata[s] : 0);
    check($sformatf("rnd%0d rvalid", cyc), rvalid_o, e_rv);
    check($sformatf("rnd%0d rdata/err", cyc), {err_o, rdata_o}, {mgr_err, mgr_rdata});
    check($sformatf("rnd%0d perr", cyc), perr, m_perr);
    if (mgr_rvalid) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      else m_perr = 1;
    end
    if (e_req && mgr_gnt) begin
      m_q.push_back(s);
      m_rr = (s + 1) % N;
      m_hold = 0;
    end else if (e_req) begin
      m_hold = 1; m_hidx = s;
    end
  endtask

  initial begin
    vecs[0]  = '{3'b111, 3'b000, 1'b1, 1'b0, 3'b001, 3'b000, 1'b1, 1'b0};
    vecs[1]  = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b010, 3'b001, 1'b1, 1'b0};
    vecs[2]  = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b100, 3'b010, 1'b1, 1'b0};
    vecs[3]  = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b001, 3'b100, 1'b1, 1'b0};
    vecs[4]  = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b010, 3'b001, 1'b1, 1'b0};
    vecs[5]  = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b100, 3'b010, 1'b1, 1'b0};
    vecs[6]  = '{3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 3'b100, 1'b0, 1'b0};
    vecs[7]  = '{3'b111, 3'b001, 1'b1, 1'b0, 3'b001, 3'b000, 1'b1, 1'b0};
    vecs[8]  = '{3'b111, 3'b001, 1'b1, 1'b1, 3'b001, 3'b001, 1'b1, 1'b0};
    vecs[9]  = '{3'b111, 3'b001, 1'b1, 1'b1, 3'b001, 3'b001, 1'b1, 1'b0};
    vecs[10] = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b010, 3'b001, 1'b1, 1'b0};
    vecs[11] = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b100, 3'b010, 1'b1, 1'b0};
    vecs[12] = '{3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 3'b100, 1'b0, 1'b0};
    vecs[13] = '{3'b111, 3'b000, 1'b1, 1'b0, 3'b001, 3'b000, 1'b1, 1'b0};
    vecs[14] = '{3'b111, 3'b000, 1'b1, 1'b0, 3'b010, 3'b000, 1'b1, 1'b0};
    vecs[15] = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b000, 3'b001, 1'b0, 1'b0};
    vecs[16] = '{3'b111, 3'b000, 1'b1, 1'b0, 3'b100, 3'b000, 1'b1, 1'b0};
    vecs[17] = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b000, 3'b010, 1'b0, 1'b0};
    vecs[18] = '{3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 3'b100, 1'b0, 1'b0};
    vecs[19] = '{3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0};
    vecs[20] = '{3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1};
    vecs[21] = '{3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1};

    clear_inputs();
    do_reset("reset0");

    // Fairness, priority, backpressure and protocol error.
    for (int i = 0; i < 22; i++) begin
      @(negedge clk_i);
      req = vecs[i].req; prio = vecs[i].prio;
      mgr_gnt = vecs[i].gnt; mgr_rvalid = vecs[i].rv;
      #1;
      check($sformatf("vec%0d gnt", i), gnt_o, vecs[i].e_gnt);
      check($sformatf("vec%0d rvalid", i), rvalid_o, vecs[i].e_rv);
      check($sformatf("vec%0d mgr_req", i), mgr_req, vecs[i].e_req);
      check($sformatf("vec%0d perr", i), perr, vecs[i].e_perr);
    end

    do_reset("reset_perr");

    // Hold: address of requester 2 stays selected until granted.
    addr[0] = 32'hAAAA_0000; addr[2] = 32'hCCCC_0000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      req = (i < 3) ? 3'b100 : 3'b101;
      prio = (i < 3) ? 3'b000 : 3'b001;
      mgr_gnt = (i >= 4);
      #1;
      check($sformatf("hold%0d mgr_req", i), mgr_req, 1);
      check($sformatf("hold%0d addr", i), mgr_addr, (i == 5) ? 32'hAAAA_0000 : 32'hCCCC_0000);
      check($sformatf("hold%0d gnt", i), gnt_o, (i == 4) ? 3'b100 : (i == 5) ? 3'b001 : 3'b000);
    end
    @(negedge clk_i);
    req = '0; prio = '0; mgr_gnt = 1'b0; mgr_rvalid = 1'b1;
    #1;
    check("hold rsp0", rvalid_o, 3'b100);
    @(negedge clk_i);
    #1;
    check("hold rsp1", rvalid_o, 3'b001);

    // Randomized run against the reference model.
    do_reset("reset_rnd");
    m_q.delete(); m_rr = 0; m_hidx = 0; m_hold = 0; m_perr = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk_i);
      req  = 3'($urandom);
      prio = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      mgr_gnt    = ($urandom_range(0, 3) != 0);
      mgr_rvalid = ($urandom_range(0, 2) != 0) && (c < 1900 || $urandom_range(0, 1) == 0);
      mgr_err    = 1'($urandom);
      mgr_rdata  = $urandom;
      for (int i = 0; i < N; i++) begin
        addr[i] = $urandom; wdata[i] = $urandom; be[i] = 4'($urandom); we[i] = 1'($urandom);
      end
      #1;
      model_cycle(c);
    end

`ifdef ZEROHETI_ARB_STATS_EN
    do_reset("reset_stats");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      req = 3'b010; mgr_gnt = 1'b1; mgr_rvalid = (i > 0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      req = 3'b010; mgr_gnt = 1'b0; mgr_rvalid = (i == 0);
    end
    @(negedge clk_i);
    req = '0; mgr_rvalid = 1'b0;
    #1;
    check("stats grant1", grant_cnt[1], 16'd5);
    check("stats stall", stall_cnt, 16'd3);
    do_reset("reset_sat");
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk_i);
      req = 3'b001; mgr_gnt = 1'b1; mgr_rvalid = (i > 0);
    end
    @(negedge clk_i);
    req = '0; mgr_gnt = 1'b0; mgr_rvalid = 1'b1;
    #1;
    check("stats sat", grant_cnt[0], 16'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
